// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: drives commands onto a purely combinational ripple ALU.
// A command is accepted over valid/ready. Its operands are held on the ALU for
// SETTLE cycles, the result is sampled, and it is returned through a small
// result FIFO. An illegal op never reaches the ALU: it is answered at once with
// data 0 and the illegal flag set. At most one command is in flight, and a
// command is accepted only when the FIFO has a free slot. This guarantees that
// every capture can push.
module alu_cmd_issuer #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2,
  parameter int DEPTH  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_signal,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       rsp_op,
  output logic             rsp_illegal,
  output logic             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [3:0]       SETTLE_C  = 4'(SETTLE);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  // Elaboration-time guard on the parameter ranges.
  generate
    if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
      $error("alu_cmd_issuer: SETTLE must be in 1..15");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("alu_cmd_issuer: DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_op;
  logic [WIDTH-1:0] r_cap_data;
  logic [2:0]       r_cap_op;
  logic             r_cap_illegal;

  logic [WIDTH-1:0] r_mem_data    [DEPTH];
  logic [2:0]       r_mem_op      [DEPTH];
  logic             r_mem_illegal [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_legal;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;

  // Only five op codes exist on the ALU. The remaining codes are answered
  // without driving it.
  assign w_legal  = (cmd_op == 3'b000) || (cmd_op == 3'b001) || (cmd_op == 3'b010) ||
                    (cmd_op == 3'b110) || (cmd_op == 3'b111);

  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);

  // Ready depends only on the state and the FIFO occupancy. It never looks at
  // cmd_valid.
  assign cmd_ready = (r_state == S_IDLE) && !w_full;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_push    = (r_state == S_CAPTURE);
  assign w_pop     = !w_empty && rsp_ready;

  assign busy       = (r_state != S_IDLE);
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_signal = r_alu_op;

  // FSM: latch the command, hold the ALU inputs for SETTLE cycles, sample the
  // result, then hand it to the FIFO.
  // NOTE: sequential state uses non-blocking (<=) so every register sees
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_alu_a       <= '0;
      r_alu_b       <= '0;
      r_alu_op      <= '0;
      r_cap_data    <= '0;
      r_cap_op      <= '0;
      r_cap_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cap_op <= cmd_op;
            if (w_legal) begin
              r_alu_a       <= cmd_a;
              r_alu_b       <= cmd_b;
              r_alu_op      <= cmd_op;
              r_cnt         <= SETTLE_C;
              r_cap_illegal <= 1'b0;
              r_state       <= S_DRIVE;
            end else begin
              r_cap_data    <= '0;
              r_cap_illegal <= 1'b1;
              r_state       <= S_CAPTURE;
            end
          end
        end
        S_DRIVE: begin
          if (r_cnt == 4'd1) begin
            r_cap_data <= alu_out;
            r_cnt      <= '0;
            r_state    <= S_CAPTURE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_CAPTURE: begin
          // Operands stay on the ALU through CAPTURE and are released on exit.
          r_alu_a  <= '0;
          r_alu_b  <= '0;
          r_alu_op <= '0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO bookkeeping: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_ONE;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CNT_ONE;
      end
    end
  end

  // FIFO storage: write the captured entry at the write pointer.
  // NOTE: storage is deliberately not reset. Entries are only observed through
  // the count, so a flushed FIFO never exposes stale contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr]    <= r_cap_data;
      r_mem_op[r_wr_ptr]      <= r_cap_op;
      r_mem_illegal[r_wr_ptr] <= r_cap_illegal;
    end
  end

  // The head entry is visible only while the FIFO holds something. Otherwise
  // the response fields are forced to 0.
  assign rsp_valid   = !w_empty;
  assign rsp_data    = w_empty ? '0   : r_mem_data[r_rd_ptr];
  assign rsp_op      = w_empty ? 3'b0 : r_mem_op[r_rd_ptr];
  assign rsp_illegal = w_empty ? 1'b0 : r_mem_illegal[r_rd_ptr];

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Testbench for alu_cmd_issuer. A behavioural ALU is attached whose output is
// only correct after its inputs have been stable for SETTLE cycles. A
// transaction-level model predicts readiness, ALU drive, and the ordered
// response stream every cycle.
module tb_alu_cmd_issuer;

  localparam int WIDTH  = 4;
  localparam int SETTLE = 2;
  localparam int DEPTH  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_signal;
  logic [WIDTH-1:0] alu_out;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [2:0]       rsp_op;
  logic             rsp_illegal;
  logic             busy;

  alu_cmd_issuer #(.WIDTH(WIDTH), .SETTLE(SETTLE), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_signal (alu_signal),
    .alu_out    (alu_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_op     (rsp_op),
    .rsp_illegal(rsp_illegal),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Function of the attached ALU. Illegal codes return a marker value that
  // must never reach a response.
  function automatic logic [WIDTH-1:0] alu_fn(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
      default: return WIDTH'(4'hA);
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] op);
    return (op == 3'b000) || (op == 3'b001) || (op == 3'b010) ||
           (op == 3'b110) || (op == 3'b111);
  endfunction

  // Ripple-settle model: the output is the inverted result until the inputs
  // have been held for SETTLE edges.
  logic [2*WIDTH+2:0] alu_prev = '0;
  int                 alu_stable = 0;
  always @(negedge clk) begin
    if ({alu_a, alu_b, alu_signal} != alu_prev) alu_stable <= 0;
    else                                        alu_stable <= alu_stable + 1;
    alu_prev <= {alu_a, alu_b, alu_signal};
  end
  assign alu_out = (alu_stable >= SETTLE - 1) ? alu_fn(alu_signal, alu_a, alu_b)
                                              : ~alu_fn(alu_signal, alu_a, alu_b);

  // Reference model state.
  typedef struct {
    logic [WIDTH-1:0] data;
    logic [2:0]       op;
    logic             ill;
  } rsp_t;

  rsp_t             exp_q[$];
  rsp_t             m_entry;
  logic             m_busy = 1'b0;
  logic             m_legal = 1'b0;
  int               m_rem = 0;
  logic [WIDTH-1:0] m_a = '0;
  logic [WIDTH-1:0] m_b = '0;
  logic [2:0]       m_op = '0;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic exp_ready;
    exp_ready = !m_busy && (exp_q.size() < DEPTH);
    check("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
    check("busy", 32'(busy), 32'(m_busy));
    check("rsp_valid", 32'(rsp_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
      check("rsp_op", 32'(rsp_op), 32'(exp_q[0].op));
      check("rsp_illegal", 32'(rsp_illegal), 32'(exp_q[0].ill));
    end else begin
      check("rsp_data_empty", 32'(rsp_data), 32'(0));
      check("rsp_op_empty", 32'(rsp_op), 32'(0));
      check("rsp_illegal_empty", 32'(rsp_illegal), 32'(0));
    end
    if (m_busy && m_legal) begin
      check("alu_a", 32'(alu_a), 32'(m_a));
      check("alu_b", 32'(alu_b), 32'(m_b));
      check("alu_signal", 32'(alu_signal), 32'(m_op));
    end else begin
      check("alu_a_idle", 32'(alu_a), 32'(0));
      check("alu_b_idle", 32'(alu_b), 32'(0));
      check("alu_signal_idle", 32'(alu_signal), 32'(0));
    end
  endtask

  // One cycle: check outputs at the falling edge, drive inputs, then advance
  // the model across the coming rising edge.
  task automatic step(input logic v, input logic [2:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic rr, output logic accepted);
    logic exp_ready;
    logic pop;
    logic push;
    rsp_t e;
    @(negedge clk);
    check_outputs();
    cmd_valid = v;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    rsp_ready = rr;
    accepted  = 1'b0;
    if (rst_n) begin
      exp_ready = !m_busy && (exp_q.size() < DEPTH);
      accepted  = v && exp_ready;
      pop       = (exp_q.size() > 0) && rr;
      push      = m_busy && (m_rem == 1);
      if (pop) e = exp_q.pop_front();
      if (push) begin
        exp_q.push_back(m_entry);
        m_busy = 1'b0;
      end else if (m_busy) begin
        m_rem--;
      end
      if (accepted) begin
        m_busy  = 1'b1;
        m_legal = is_legal(op);
        m_op    = op;
        m_a     = a;
        m_b     = b;
        m_entry.op = op;
        if (m_legal) begin
          m_entry.data = alu_fn(op, a, b);
          m_entry.ill  = 1'b0;
          m_rem        = SETTLE + 1;
        end else begin
          m_entry.data = '0;
          m_entry.ill  = 1'b1;
          m_rem        = 1;
        end
      end
    end
  endtask

  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic rr);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) step(1'b1, op, a, b, rr, ok);
    check("send_accept", 32'(ok), 32'(1));
  endtask

  task automatic idle(input int n, input logic rr);
    logic dummy;
    for (int i = 0; i < n; i++)
      step(1'b0, 3'($urandom), WIDTH'($urandom), WIDTH'($urandom), rr, dummy);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;
    idle(3, 1'b0);
    rst_n = 1'b1;
    idle(2, 1'b1);

    // ADD 7+5 with the consumer always ready.
    send(3'b010, 4'd7, 4'd5, 1'b1);
    idle(5, 1'b1);

    // SUB 3-5 followed immediately by SLT 3,5.
    send(3'b110, 4'd3, 4'd5, 1'b1);
    send(3'b111, 4'd3, 4'd5, 1'b1);
    idle(5, 1'b1);

    // Back-pressure: two ADDs fill the FIFO, and the third waits for a pop.
    send(3'b010, 4'd1, 4'd1, 1'b0);
    send(3'b010, 4'd2, 4'd2, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 3'b010, 4'd3, 4'd3, 1'b0, acc);
    send(3'b010, 4'd3, 4'd3, 1'b1);
    idle(6, 1'b1);

    // Illegal op with all-ones operands.
    send(3'b100, 4'hF, 4'hF, 1'b1);
    idle(3, 1'b1);

    // Push and pop on the same edge while one entry is held.
    send(3'b001, 4'h5, 4'hA, 1'b0);
    idle(4, 1'b0);
    send(3'b000, 4'hC, 4'h6, 1'b0);
    for (int i = 0; i < 10 && m_busy && m_rem != 1; i++) step(1'b0, 3'b0, 4'd0, 4'd0, 1'b0, acc);
    step(1'b0, 3'b0, 4'd0, 4'd0, 1'b1, acc);
    idle(5, 1'b1);

    // Reset in the middle of DRIVE with one response still pending.
    send(3'b010, 4'd1, 4'd1, 1'b0);
    idle(4, 1'b0);
    send(3'b010, 4'd9, 4'd9, 1'b0);
    step(1'b0, 3'b0, 4'd0, 4'd0, 1'b0, acc);
    #2 rst_n = 1'b0;
    #1;
    check("rst_alu_a", 32'(alu_a), 32'(0));
    check("rst_alu_b", 32'(alu_b), 32'(0));
    check("rst_alu_signal", 32'(alu_signal), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    exp_q.delete();
    m_busy = 1'b0;
    idle(2, 1'b1);
    rst_n = 1'b1;
    idle(10, 1'b1);

    // Randomized traffic, including illegal ops and operand churn while not accepted.
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 1)), 3'($urandom), WIDTH'($urandom), WIDTH'($urandom),
           ($urandom_range(0, 3) != 0), acc);
    idle(10, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
